// File: rtl/perf_pkg.sv
// Shared types and constants for the performance measurement window.
// Counter width and saturation value live here.
package perf_pkg;

  localparam int PERF_CNT_W = 32;
  localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } perf_state_t;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous load.
// sat flags the all-ones value so the owner can detect a lost increment.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         cpu_clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  assign sat = &q;

  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc && !sat) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/perf_window_ctrl.sv
// Start/stop PC measurement window with frozen result and valid/ack.
// Build option: PERF_INSTR_COUNT_EN implements the instruction counter.
module perf_window_ctrl
  import perf_pkg::*;
#(
  parameter logic [15:0] START_PC   = 16'h0000,
  parameter logic [15:0] STOP_PC    = 16'hFFFF,
  parameter bit          AUTO_REARM = 1'b0
) (
  input  logic        cpu_clk,
  input  logic        resetN,
  input  logic [15:0] pc,
  input  logic        pc_valid,
  input  logic        arm,
  input  logic        clear,
  input  logic        result_ack,
  output logic [1:0]  state,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic        overflow
);

  perf_state_t state_q, state_d;

  logic start_hit, stop_hit;
  logic cnt_load, ld_one;
  logic cyc_inc, ins_en;
  logic ovf_clr, ovf_set;
  logic cyc_sat, ins_sat;
  logic [PERF_CNT_W-1:0] load_val;

  assign start_hit = pc_valid && (pc == START_PC);
  assign stop_hit  = pc_valid && (pc == STOP_PC);
  assign load_val  = {{(PERF_CNT_W-1){1'b0}}, ld_one};

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    ld_one   = 1'b0;
    cyc_inc  = 1'b0;
    ins_en   = 1'b0;
    ovf_clr  = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      cnt_load = 1'b1;
      ovf_clr  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            state_d  = ARMED;
            cnt_load = 1'b1;
            ovf_clr  = 1'b1;
          end
        end
        ARMED: begin
          if (start_hit) begin
            state_d  = RUNNING;
            cnt_load = 1'b1;
            ld_one   = 1'b1;
          end
        end
        RUNNING: begin
          cyc_inc = 1'b1;
          ins_en  = pc_valid;
          if (stop_hit) state_d = DONE;
        end
        DONE: begin
          if (result_ack) begin
            if (AUTO_REARM) begin
              state_d  = ARMED;
              cnt_load = 1'b1;
              ovf_clr  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ovf_set = (cyc_inc && cyc_sat) || (ins_en && ins_sat);

  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d == ARMED) || (state_d == RUNNING);
      result_valid <= (state_d == DONE);
      if (ovf_clr) overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  assign state = state_q;

  perf_sat_counter #(.W(PERF_CNT_W)) u_cyc_cnt (
    .cpu_clk  (cpu_clk),
    .resetN   (resetN),
    .load     (cnt_load),
    .load_val (load_val),
    .inc      (cyc_inc),
    .q        (cycle_count),
    .sat      (cyc_sat)
  );

`ifdef PERF_INSTR_COUNT_EN
  perf_sat_counter #(.W(PERF_CNT_W)) u_ins_cnt (
    .cpu_clk  (cpu_clk),
    .resetN   (resetN),
    .load     (cnt_load),
    .load_val (load_val),
    .inc      (ins_en),
    .q        (instr_count),
    .sat      (ins_sat)
  );
`else
  logic unused_ins;
  assign unused_ins  = ins_en;
  assign ins_sat     = 1'b0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Bench for perf_window_ctrl: two instances, spec-level model, literals.
// Works with or without PERF_INSTR_COUNT_EN defined.
module tb_perf_window_ctrl;

`ifdef PERF_INSTR_COUNT_EN
  localparam bit IEN = 1'b1;
`else
  localparam bit IEN = 1'b0;
`endif
  localparam longint MAXV = 64'hFFFF_FFFF;

  logic        cpu_clk = 1'b0;
  logic        resetN = 1'b0;
  logic [15:0] pc = 16'h0;
  logic        pc_valid = 1'b0;
  logic        arm = 1'b0;
  logic        clear = 1'b0;
  logic        result_ack = 1'b0;

  logic [1:0]  d_st [2];
  logic        d_busy [2];
  logic        d_rv [2];
  logic [31:0] d_cyc [2];
  logic [31:0] d_ins [2];
  logic        d_ovf [2];

  int errs = 0;
  int checks = 0;

  always #5 cpu_clk = ~cpu_clk;

  perf_window_ctrl #(
    .START_PC(16'h0010), .STOP_PC(16'h0020), .AUTO_REARM(1'b0)
  ) dut (
    .cpu_clk(cpu_clk), .resetN(resetN), .pc(pc), .pc_valid(pc_valid),
    .arm(arm), .clear(clear), .result_ack(result_ack),
    .state(d_st[0]), .busy(d_busy[0]), .result_valid(d_rv[0]),
    .cycle_count(d_cyc[0]), .instr_count(d_ins[0]),
    .overflow(d_ovf[0])
  );

  perf_window_ctrl #(
    .START_PC(16'h0040), .STOP_PC(16'h0040), .AUTO_REARM(1'b1)
  ) dut2 (
    .cpu_clk(cpu_clk), .resetN(resetN), .pc(pc), .pc_valid(pc_valid),
    .arm(arm), .clear(clear), .result_ack(result_ack),
    .state(d_st[1]), .busy(d_busy[1]), .result_valid(d_rv[1]),
    .cycle_count(d_cyc[1]), .instr_count(d_ins[1]),
    .overflow(d_ovf[1])
  );

  // Model: state as int 0..3, counts as wide integers clamped to MAXV.
  int     m_st [2];
  longint m_cyc [2];
  longint m_ins [2];
  bit     m_ovf [2];
  logic [15:0] m_start [2] = '{16'h0010, 16'h0040};
  logic [15:0] m_stop  [2] = '{16'h0020, 16'h0040};
  bit          m_rearm [2] = '{1'b0, 1'b1};

  always @(posedge cpu_clk or negedge resetN) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetN || clear) begin
        m_st[i] = 0; m_cyc[i] = 0; m_ins[i] = 0; m_ovf[i] = 0;
      end else if (m_st[i] == 0) begin
        if (arm) begin
          m_st[i] = 1; m_cyc[i] = 0; m_ins[i] = 0; m_ovf[i] = 0;
        end
      end else if (m_st[i] == 1) begin
        if (pc_valid && pc == m_start[i]) begin
          m_st[i] = 2; m_cyc[i] = 1; m_ins[i] = IEN ? 1 : 0;
        end
      end else if (m_st[i] == 2) begin
        if (m_cyc[i] == MAXV) m_ovf[i] = 1;
        else m_cyc[i] = m_cyc[i] + 1;
        if (pc_valid && IEN) begin
          if (m_ins[i] == MAXV) m_ovf[i] = 1;
          else m_ins[i] = m_ins[i] + 1;
        end
        if (pc_valid && pc == m_stop[i]) m_st[i] = 3;
      end else begin
        if (result_ack) begin
          if (m_rearm[i]) begin
            m_st[i] = 1; m_cyc[i] = 0; m_ins[i] = 0; m_ovf[i] = 0;
          end else begin
            m_st[i] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge cpu_clk) begin
    if (resetN) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("state[%0d]", i), longint'(d_st[i]), longint'(m_st[i]));
        chk($sformatf("busy[%0d]", i), longint'(d_busy[i]),
            longint'(m_st[i] == 1 || m_st[i] == 2));
        chk($sformatf("rv[%0d]", i), longint'(d_rv[i]), longint'(m_st[i] == 3));
        chk($sformatf("cyc[%0d]", i), longint'(d_cyc[i]), m_cyc[i]);
        chk($sformatf("ins[%0d]", i), longint'(d_ins[i]), m_ins[i]);
        chk($sformatf("ovf[%0d]", i), longint'(d_ovf[i]), longint'(m_ovf[i]));
      end
    end
  end

  task automatic tick(input logic a, input logic v, input logic [15:0] p,
                      input logic c, input logic k);
    arm = a; pc_valid = v; pc = p; clear = c; result_ack = k;
    @(negedge cpu_clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick(0, 0, 16'h0, 0, 0);
  endtask

  initial begin
    @(negedge cpu_clk);
    #2 resetN = 1'b0;
    @(negedge cpu_clk);
    chk("rst_state", longint'(d_st[0]), 0);
    chk("rst_cyc", longint'(d_cyc[0]), 0);
    #2 resetN = 1'b1;
    @(negedge cpu_clk);
    idle(2);

    // Basic window on dut: start 10, five retires, stop 40.
    for (int c = 0; c <= 45; c++) begin
      if (c == 0) tick(1, 0, 16'h0, 0, 0);
      else if (c == 10) tick(0, 1, 16'h0010, 0, 0);
      else if (c == 40) tick(0, 1, 16'h0020, 0, 0);
      else if (c >= 14 && c <= 30 && (c % 4) == 2) tick(0, 1, 16'h0100, 0, 0);
      else tick(0, 0, 16'h0, 0, 0);
      if (c == 39) chk("basic_rv_before", longint'(d_rv[0]), 0);
      if (c == 40) chk("basic_rv_at41", longint'(d_rv[0]), 1);
    end
    chk("basic_cyc", longint'(d_cyc[0]), 31);
    chk("basic_ins", longint'(d_ins[0]), IEN ? 7 : 0);
    tick(0, 0, 16'h0, 0, 1);
    chk("ack_idle", longint'(d_st[0]), 0);
    chk("ack_rv", longint'(d_rv[0]), 0);
    chk("ack_hold_cyc", longint'(d_cyc[0]), 31);

    // dut2 is still armed: START==STOP retired at 5 and 12.
    for (int c = 0; c <= 15; c++) begin
      if (c == 5 || c == 12) tick(0, 1, 16'h0040, 0, 0);
      else tick(0, 0, 16'h0, 0, 0);
    end
    chk("same_pc_cyc", longint'(d_cyc[1]), 8);
    chk("same_pc_ins", longint'(d_ins[1]), IEN ? 2 : 0);
    tick(0, 0, 16'h0, 0, 1);
    chk("rearm_state", longint'(d_st[1]), 1);
    chk("rearm_cyc", longint'(d_cyc[1]), 0);

    // Second window on dut2 with arm pulsed mid-run.
    tick(0, 1, 16'h0040, 0, 0);
    tick(1, 0, 16'h0, 0, 0);
    chk("arm_run_state", longint'(d_st[1]), 2);
    tick(0, 1, 16'h0001, 0, 0);
    tick(0, 1, 16'h0040, 0, 0);
    chk("win2_cyc", longint'(d_cyc[1]), 4);
    chk("win2_ins", longint'(d_ins[1]), IEN ? 3 : 0);
    tick(0, 0, 16'h0, 0, 1);

    // Clear coincident with stop retire.
    tick(0, 0, 16'h0, 1, 0);
    tick(1, 0, 16'h0, 0, 0);
    tick(0, 1, 16'h0010, 0, 0);
    idle(3);
    tick(0, 1, 16'h0020, 1, 0);
    chk("clr_state", longint'(d_st[0]), 0);
    chk("clr_cyc", longint'(d_cyc[0]), 0);
    idle(2);
    chk("clr_no_rv", longint'(d_rv[0]), 0);

    // Saturation of the cycle counter.
    tick(1, 0, 16'h0, 0, 0);
    tick(0, 1, 16'h0010, 0, 0);
    #2;
    force dut.u_cyc_cnt.q = 32'hFFFF_FFFE;
    m_cyc[0] = 64'hFFFF_FFFE;
    #1;
    release dut.u_cyc_cnt.q;
    idle(3);
    chk("sat_cyc", longint'(d_cyc[0]), 64'hFFFF_FFFF);
    chk("sat_ovf", longint'(d_ovf[0]), 1);
    tick(0, 1, 16'h0020, 0, 0);
    tick(0, 0, 16'h0, 0, 1);
    chk("sat_ovf_idle", longint'(d_ovf[0]), 1);
    tick(1, 0, 16'h0, 0, 0);
    chk("arm_clr_ovf", longint'(d_ovf[0]), 0);

    // Asynchronous reset mid-run.
    tick(0, 1, 16'h0010, 0, 0);
    idle(2);
    #2 resetN = 1'b0;
    #1;
    chk("arst_state", longint'(d_st[0]), 0);
    chk("arst_busy", longint'(d_busy[0]), 0);
    chk("arst_cyc", longint'(d_cyc[0]), 0);
    chk("arst_rv", longint'(d_rv[0]), 0);
    @(negedge cpu_clk);
    #2 resetN = 1'b1;
    @(negedge cpu_clk);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/perf_window_ctrl.md
# perf_window_ctrl

Measurement-window controller for the CPU performance display. It sequences the cycle and instruction counters between a programmable start PC and stop PC, freezes the results, and hands them to the VGA overlay through a valid/ack handshake. The block sits between the core's retire stream and the hex/decimal digit renderers. It replaces free-running "count until final PC" behaviour with re-armable, repeatable measurement runs.

## Interface
Parameters:
- START_PC, 16'h0000, PC whose retirement opens the window
- STOP_PC, 16'hFFFF, PC whose retirement closes the window
- AUTO_REARM, 0, 1 = return to ARMED instead of IDLE after result_ack

Ports:
- cpu_clk  in  1  CPU clock; all logic on posedge
- resetN  in  1  reset, asynchronous, active-low
- pc  in  16  PC of the instruction retiring this cycle
- pc_valid  in  1  an instruction retires this cycle
- arm  in  1  single-cycle pulse; IDLE -> ARMED
- clear  in  1  synchronous abort/clear, highest priority
- result_ack  in  1  display has consumed the frozen result
- state  out  2  current FSM state (perf_pkg encoding)
- busy  out  1  state is ARMED or RUNNING
- result_valid  out  1  frozen result available (state DONE)
- cycle_count  out  32  cycles in window, inclusive of start and stop
- instr_count  out  32  retired instructions in window, inclusive
- overflow  out  1  sticky; a counter saturated during the run

## Operation
- States: IDLE=0, ARMED=1, RUNNING=2, DONE=3.
- IDLE: counts hold their last values. On arm: go to ARMED, zero both counts, clear overflow.
- ARMED: on pc_valid && pc==START_PC, go to RUNNING and load cycle_count=1, instr_count=1.
- RUNNING:
  - cycle_count increments every cycle.
  - instr_count increments on each pc_valid.
  - On pc_valid && pc==STOP_PC, perform the final increment (inclusive) and go to DONE.
  - The retire that starts the window never also stops it, even if START_PC==STOP_PC. Stop requires a later retire.
- DONE: counts frozen and result_valid=1. On result_ack, go to IDLE (AUTO_REARM=0) or ARMED (AUTO_REARM=1). ARMED entered via auto-rearm zeroes both counts and overflow.
- arm outside IDLE is ignored. result_ack outside DONE is ignored.
- clear in any state: go to IDLE, both counts=0, overflow=0. clear has priority over arm, ack and start/stop matches in the same cycle.
- Arithmetic: counters are 32-bit unsigned and saturating at 32'hFFFF_FFFF. An increment attempted at saturation holds the value and sets overflow. overflow stays set until arm, auto-rearm or clear.

## Timing
- All outputs are registered. Reset values: state=IDLE, busy=0, result_valid=0, cycle_count=0, instr_count=0, overflow=0.
- ARMED -> RUNNING: state and counts update on the edge ending the matching cycle.
- result_valid rises the cycle after the stop-match cycle.
- result_ack sampled high drops result_valid the next cycle. Minimum DONE residency is 1 cycle.
- Minimal window: start retire at cycle N, stop retire at N+1 gives cycle_count=2, instr_count=2.
- resetN asserted mid-run returns immediately to reset values; no partial result is presented.

## Configuration
- PERF_INSTR_COUNT_EN defined: instr_count is implemented as specified.
- Not defined: the instr_count counter is removed. The port is tied to 32'h0 and overflow reflects cycle_count only. pc_valid still qualifies start/stop matches.

## Structure
- perf_pkg holds:
  - perf_state_t enum (IDLE/ARMED/RUNNING/DONE, 2-bit)
  - PERF_CNT_W=32
  - PERF_CNT_MAX constant
- Sub-module perf_sat_counter: parameterised-width saturating counter. Inputs: load, load_val, inc. Outputs: q, sat. Instantiated once per counter.
- FSM and match logic live in perf_window_ctrl.

## Test plan
- Basic window: arm; retire START_PC at cycle 10, 5 more retires over 20 cycles, then STOP_PC at cycle 40 -> cycle_count=31, instr_count=7, result_valid at cycle 41.
- START_PC==STOP_PC=16'h0040, retired at cycles 5 and 12 -> window is 5..12: cycle_count=8, instr_count=2.
- Saturation: force cycle_count to 32'hFFFF_FFFE, run 3 more cycles -> holds 32'hFFFF_FFFF, overflow=1; next arm clears overflow.
- clear asserted in the same cycle as a STOP_PC retire -> state=IDLE, counts=0, result_valid never asserts.
- AUTO_REARM=1: ack in DONE -> ARMED with counts zeroed; a second window measures independently. arm pulsed during RUNNING has no effect.
- resetN dropped mid-RUNNING -> all outputs at reset values asynchronously. Build without PERF_INSTR_COUNT_EN -> instr_count=0 in every scenario above.
